// File: rtl/gpr_sb_pkg.sv
// Shared encodings and segment-mask helper for the x86 GPR scoreboard.
// Every GPR splits into seg0=[7:0], seg1=[15:8], seg2=[31:16]; flag bit index is reg*3+seg.
package gpr_sb_pkg;

    localparam int NUM_GPR = 8;
    localparam int NUM_SEG = 3;
    localparam int SB_W    = NUM_GPR * NUM_SEG;

    localparam logic [1:0] SIZE_8  = 2'b00;
    localparam logic [1:0] SIZE_16 = 2'b01;
    localparam logic [1:0] SIZE_32 = 2'b10;
    localparam logic [1:0] SIZE_64 = 2'b11;

    localparam int SEG_LO = 0;
    localparam int SEG_HI = 1;
    localparam int SEG_UP = 2;

    // 8-bit ids 4..7 are AH..BH, i.e. the high byte of registers 0..3.
    function automatic logic [SB_W-1:0] gpr_seg_mask(input logic [2:0] reg_id,
                                                     input logic [1:0] size);
        logic [SB_W-1:0] mask;
        int              base;
        mask = '0;
        base = int'(reg_id) * NUM_SEG;
        case (size)
            SIZE_8: begin
                if (reg_id[2]) mask[int'(reg_id[1:0]) * NUM_SEG + SEG_HI] = 1'b1;
                else           mask[int'(reg_id[1:0]) * NUM_SEG + SEG_LO] = 1'b1;
            end
            SIZE_16: begin
                mask[base + SEG_LO] = 1'b1;
                mask[base + SEG_HI] = 1'b1;
            end
            SIZE_32: begin
                mask[base + SEG_LO] = 1'b1;
                mask[base + SEG_HI] = 1'b1;
                mask[base + SEG_UP] = 1'b1;
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/gpr_sb_counter.sv
// One saturating in-flight writer counter for a single GPR segment.
// Simultaneous inc and dec cancel; flush wins over both.
module gpr_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic flush,
    output logic zero,
    output logic one,
    output logic full,
    output logic underflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero      = (cnt_q == '0);
    assign one       = (cnt_q == CNT_ONE);
    assign full      = (cnt_q == CNT_MAX);
    assign underflow = dec & ~inc & zero;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (inc && !dec && !full)
            cnt_d = cnt_q + CNT_ONE;
        else if (dec && !inc && !zero)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gpr_scoreboard_unit.sv
// GPR scoreboard with per-segment in-flight counters, allocate/retire and NUM_CHK RAW check ports.
// Define GPR_SB_BYPASS_EN to let checks ignore segments freed by the same-cycle writeback or flush.
module gpr_scoreboard_unit
    import gpr_sb_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int NUM_CHK = 2
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 FLUSH,
    input  logic                 ALLOC_V,
    input  logic [2:0]           ALLOC_REG,
    input  logic [1:0]           ALLOC_SIZE,
    output logic                 ALLOC_STALL,
    input  logic                 RET_V,
    input  logic [2:0]           RET_REG,
    input  logic [1:0]           RET_SIZE,
    input  logic [NUM_CHK-1:0]   CHK_V,
    input  logic [NUM_CHK-1:0]   CHK_NEEDED,
    input  logic [3*NUM_CHK-1:0] CHK_REG,
    input  logic [2*NUM_CHK-1:0] CHK_SIZE,
    output logic [NUM_CHK-1:0]   CHK_STALL,
    output logic [SB_W-1:0]      GPR_SCOREBOARD,
    output logic                 SB_ERR
);

`ifdef GPR_SB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic [SB_W-1:0] alloc_mask;
    logic [SB_W-1:0] ret_mask;
    logic [SB_W-1:0] inc_vec;
    logic [SB_W-1:0] dec_vec;
    logic [SB_W-1:0] zero_vec;
    logic [SB_W-1:0] one_vec;
    logic [SB_W-1:0] full_vec;
    logic [SB_W-1:0] uflow_vec;
    logic [SB_W-1:0] busy_chk;
    logic            sb_err_q;
    logic            sb_err_d;

    assign alloc_mask  = gpr_seg_mask(ALLOC_REG, ALLOC_SIZE);
    assign ret_mask    = gpr_seg_mask(RET_REG, RET_SIZE);
    assign ALLOC_STALL = ALLOC_V & |(alloc_mask & full_vec);
    assign inc_vec     = {SB_W{ALLOC_V & ~ALLOC_STALL}} & alloc_mask;
    assign dec_vec     = {SB_W{RET_V}} & ret_mask;

    for (genvar s = 0; s < SB_W; s++) begin : g_cnt
        gpr_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (CLK),
            .rst_n     (CLR),
            .inc       (inc_vec[s]),
            .dec       (dec_vec[s]),
            .flush     (FLUSH),
            .zero      (zero_vec[s]),
            .one       (one_vec[s]),
            .full      (full_vec[s]),
            .underflow (uflow_vec[s])
        );
    end

    assign GPR_SCOREBOARD = ~zero_vec;

    // A last writer retiring this cycle frees its segment for checks only in bypass builds.
    assign busy_chk = ~zero_vec & ~({SB_W{BYPASS & ~FLUSH}} & one_vec & dec_vec);

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_chk
        logic [SB_W-1:0] chk_mask;
        assign chk_mask     = gpr_seg_mask(CHK_REG[3*i +: 3], CHK_SIZE[2*i +: 2]);
        assign CHK_STALL[i] = CHK_V[i] & CHK_NEEDED[i] & ~(BYPASS & FLUSH) &
                              |(chk_mask & busy_chk);
    end

    always_comb begin
        sb_err_d = sb_err_q | (|uflow_vec);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) sb_err_q <= 1'b0;
        else      sb_err_q <= sb_err_d;
    end

    assign SB_ERR = sb_err_q;

endmodule

// File: tb/tb_gpr_scoreboard_unit.sv
// Directed bench for gpr_scoreboard_unit: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_gpr_scoreboard_unit;

`ifdef GPR_SB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam int K_CHK = 0;
    localparam int K_AS  = 1;
    localparam int K_SB  = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        FLUSH;
    logic        ALLOC_V;
    logic [2:0]  ALLOC_REG;
    logic [1:0]  ALLOC_SIZE;
    logic        ALLOC_STALL;
    logic        RET_V;
    logic [2:0]  RET_REG;
    logic [1:0]  RET_SIZE;
    logic [1:0]  CHK_V;
    logic [1:0]  CHK_NEEDED;
    logic [5:0]  CHK_REG;
    logic [3:0]  CHK_SIZE;
    logic [1:0]  CHK_STALL;
    logic [23:0] GPR_SCOREBOARD;
    logic        SB_ERR;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    gpr_scoreboard_unit #(.CNT_W(2), .NUM_CHK(2)) dut (
        .CLK            (CLK),
        .CLR            (CLR),
        .FLUSH          (FLUSH),
        .ALLOC_V        (ALLOC_V),
        .ALLOC_REG      (ALLOC_REG),
        .ALLOC_SIZE     (ALLOC_SIZE),
        .ALLOC_STALL    (ALLOC_STALL),
        .RET_V          (RET_V),
        .RET_REG        (RET_REG),
        .RET_SIZE       (RET_SIZE),
        .CHK_V          (CHK_V),
        .CHK_NEEDED     (CHK_NEEDED),
        .CHK_REG        (CHK_REG),
        .CHK_SIZE       (CHK_SIZE),
        .CHK_STALL      (CHK_STALL),
        .GPR_SCOREBOARD (GPR_SCOREBOARD),
        .SB_ERR         (SB_ERR)
    );

    always #5 CLK = ~CLK;

    // Monitor: everything queued during the current cycle is checked at the falling edge.
    always @(negedge CLK) begin
        exp_t        it;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            case (it.kind)
                K_CHK:   act = {30'b0, CHK_STALL};
                K_AS:    act = {31'b0, ALLOC_STALL};
                K_SB:    act = {8'b0, GPR_SCOREBOARD};
                default: act = {31'b0, SB_ERR};
            endcase
            tests_run++;
            if (act !== it.exp) begin
                tests_failed++;
                $display("[TB] FAIL %s: got %0h, expected %0h", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input string name, input logic [31:0] v);
        exp_t it;
        it.kind = kind;
        it.name = name;
        it.exp  = v;
        exp_q.push_back(it);
    endtask

    task automatic drive_idle();
        FLUSH      = 1'b0;
        ALLOC_V    = 1'b0;
        ALLOC_REG  = '0;
        ALLOC_SIZE = '0;
        RET_V      = 1'b0;
        RET_REG    = '0;
        RET_SIZE   = '0;
        CHK_V      = '0;
        CHK_NEEDED = '0;
        CHK_REG    = '0;
        CHK_SIZE   = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        drive_idle();
    endtask

    task automatic set_alloc(input logic [2:0] r, input logic [1:0] s);
        ALLOC_V    = 1'b1;
        ALLOC_REG  = r;
        ALLOC_SIZE = s;
    endtask

    task automatic set_ret(input logic [2:0] r, input logic [1:0] s);
        RET_V    = 1'b1;
        RET_REG  = r;
        RET_SIZE = s;
    endtask

    task automatic set_chk(input int p, input logic [2:0] r, input logic [1:0] s, input logic needed);
        CHK_V[p]          = 1'b1;
        CHK_NEEDED[p]     = needed;
        CHK_REG[3*p +: 3] = r;
        CHK_SIZE[2*p +: 2] = s;
    endtask

    initial begin
        CLR = 1'b0;
        drive_idle();
        expect_val(K_SB,  "reset_sb", 32'h0);
        expect_val(K_ERR, "reset_err", 32'h0);
        expect_val(K_AS,  "reset_as", 32'h0);
        expect_val(K_CHK, "reset_chk", 32'h0);
        next_cycle();
        CLR = 1'b1;

        // 1: 32b EAX check with empty scoreboard
        next_cycle();
        set_chk(0, 3'd0, 2'b10, 1'b1);
        set_chk(1, 3'd0, 2'b10, 1'b0);
        expect_val(K_CHK, "t1_chk_eax", 32'h0);
        expect_val(K_SB,  "t1_sb", 32'h0);

        // 2: AH aliasing
        next_cycle();
        set_alloc(3'd4, 2'b00);
        expect_val(K_AS, "t2_alloc_ah", 32'h0);
        next_cycle();
        set_chk(0, 3'd0, 2'b00, 1'b1);
        set_chk(1, 3'd4, 2'b00, 1'b1);
        expect_val(K_SB,  "t2_sb_ah", 32'h000002);
        expect_val(K_CHK, "t2_chk_al_ah", 32'h2);
        next_cycle();
        set_chk(0, 3'd0, 2'b01, 1'b1);
        set_chk(1, 3'd0, 2'b11, 1'b1);
        expect_val(K_CHK, "t2_chk_ax_64", 32'h1);
        next_cycle();
        set_ret(3'd4, 2'b00);
        next_cycle();
        expect_val(K_SB, "t2_sb_clean", 32'h0);

        // 3: ECX saturation
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_alloc(3'd1, 2'b10);
            expect_val(K_AS, "t3_alloc_fill", 32'h0);
        end
        next_cycle();
        set_alloc(3'd1, 2'b10);
        expect_val(K_AS, "t3_alloc_sat", 32'h1);
        expect_val(K_SB, "t3_sb_ecx", 32'h000038);
        next_cycle();
        set_alloc(3'd1, 2'b10);
        set_ret(3'd1, 2'b10);
        expect_val(K_AS, "t3_alloc_ret_sat", 32'h1);
        expect_val(K_SB, "t3_sb_still", 32'h000038);
        next_cycle();
        set_alloc(3'd1, 2'b10);
        set_ret(3'd1, 2'b10);
        expect_val(K_AS, "t3_alloc_ret_2", 32'h0);
        next_cycle();
        set_alloc(3'd1, 2'b10);
        expect_val(K_AS, "t3_alloc_to3", 32'h0);
        next_cycle();
        set_alloc(3'd1, 2'b10);
        expect_val(K_AS, "t3_alloc_sat2", 32'h1);
        next_cycle();
        set_alloc(3'd1, 2'b11);
        expect_val(K_AS, "t3_alloc_64", 32'h0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_ret(3'd1, 2'b10);
            expect_val(K_SB, "t3_sb_draining", 32'h000038);
        end
        next_cycle();
        expect_val(K_SB,  "t3_sb_drained", 32'h0);
        expect_val(K_ERR, "t3_no_err", 32'h0);

        // 4: retire/check bypass on DX
        next_cycle();
        set_alloc(3'd2, 2'b01);
        next_cycle();
        set_ret(3'd2, 2'b01);
        set_chk(0, 3'd2, 2'b01, 1'b1);
        expect_val(K_SB,  "t4_sb_dx", 32'h0000C0);
        expect_val(K_CHK, "t4_chk_same", BYP ? 32'h0 : 32'h1);
        next_cycle();
        set_chk(0, 3'd2, 2'b01, 1'b1);
        expect_val(K_CHK, "t4_chk_next", 32'h0);
        expect_val(K_SB,  "t4_sb_clean", 32'h0);

        // 5: underflow on EBX
        next_cycle();
        set_ret(3'd3, 2'b10);
        expect_val(K_ERR, "t5_err_before", 32'h0);
        next_cycle();
        expect_val(K_ERR, "t5_err_set", 32'h1);
        expect_val(K_SB,  "t5_sb_zero", 32'h0);
        next_cycle();
        FLUSH = 1'b1;
        next_cycle();
        expect_val(K_ERR, "t5_err_after_flush", 32'h1);

        // 6: fill all, flush with concurrent traffic, async clear
        for (int r = 0; r < 8; r++) begin
            next_cycle();
            set_alloc(3'(r), 2'b10);
            expect_val(K_AS, "t6_alloc_all", 32'h0);
        end
        next_cycle();
        set_chk(1, 3'd5, 2'b00, 1'b1);
        expect_val(K_SB,  "t6_sb_full", 32'hFFFFFF);
        expect_val(K_CHK, "t6_chk_ch", 32'h2);
        next_cycle();
        FLUSH = 1'b1;
        set_alloc(3'd0, 2'b10);
        set_ret(3'd1, 2'b10);
        set_chk(0, 3'd0, 2'b10, 1'b1);
        expect_val(K_AS,  "t6_flush_as", 32'h0);
        expect_val(K_SB,  "t6_flush_sb", 32'hFFFFFF);
        expect_val(K_CHK, "t6_flush_chk", BYP ? 32'h0 : 32'h1);
        next_cycle();
        set_chk(0, 3'd0, 2'b10, 1'b1);
        expect_val(K_SB,  "t6_sb_flushed", 32'h0);
        expect_val(K_CHK, "t6_chk_flushed", 32'h0);
        expect_val(K_ERR, "t6_err_kept", 32'h1);
        next_cycle();
        set_alloc(3'd7, 2'b10);
        next_cycle();
        set_alloc(3'd7, 2'b10);
        next_cycle();
        expect_val(K_SB, "t6_sb_edi", 32'hE00000);
        next_cycle();
        #2;
        CLR = 1'b0;
        expect_val(K_SB,  "t6_async_sb", 32'h0);
        expect_val(K_ERR, "t6_async_err", 32'h0);
        next_cycle();
        CLR = 1'b1;
        next_cycle();
        expect_val(K_SB, "t6_after_clr", 32'h0);

        next_cycle();
        next_cycle();
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL queue_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
